// File: rtl/bingo_pkg.sv
// Shared definitions for the bingo turn scheduler: FSM encodings, cell count
// and a helper that turns a called number into its one-hot cell mask.
package bingo_pkg;

  localparam int NUM_CELLS = 25;
  localparam int NUM_W     = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    WAIT_SEL  = 3'd2,
    WAIT_PEER = 3'd3,
    MY_TURN   = 3'd4,
    PEER_TURN = 3'd5,
    CHECK     = 3'd6,
    OVER      = 3'd7
  } state_t;

  // Numbers outside 1..NUM_CELLS map to an empty mask, so they can never be accepted.
  function automatic logic [NUM_CELLS-1:0] num_to_mask(input logic [NUM_W-1:0] num);
    logic [NUM_CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (num == NUM_W'(i + 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lowest_free_finder.sv
// Priority encoder returning the lowest number (1-based) whose called bit is
// still clear; valid_o drops when every number has been called.
module lowest_free_finder
  import bingo_pkg::*;
(
  input  logic [NUM_CELLS-1:0] mask_i,
  output logic [NUM_W-1:0]     num_o,
  output logic                 valid_o
);

  // Scan from the top down so the lowest free cell is the last one written.
  always_comb begin
    num_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (!mask_i[i]) begin
        num_o   = NUM_W'(i + 1);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencing for a two-board bingo game: setup handshake, alternating
// picks, line-check wait and win/draw detection. Optional macro
// TURN_TIMEOUT_EN adds an auto-pick of the lowest free number after a stalled MY_TURN.
module turn_scheduler
  import bingo_pkg::*;
#(
  parameter int WIN_LINES      = 5,
  parameter int CHECK_LAT      = 2,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 game_start,
  input  logic                 first_player,
  input  logic                 sel_done,
  input  logic                 peer_ready,
  input  logic                 pick_valid,
  input  logic [NUM_W-1:0]     pick_num,
  input  logic                 peer_valid,
  input  logic [NUM_W-1:0]     peer_num,
  input  logic [3:0]           line_count,
  input  logic                 peer_win,
  output logic                 clear_sel,
  output logic                 start_sel,
  output logic                 my_turn,
  output logic [NUM_CELLS-1:0] called,
  output logic                 send_valid,
  output logic [NUM_W-1:0]     send_num,
  output logic [2:0]           state,
  output logic                 win_local,
  output logic                 win_peer
);

  state_t               state_q, state_d;
  logic [NUM_CELLS-1:0] called_q, called_d;
  logic                 first_q, first_d;
  logic                 last_local_q, last_local_d;
  logic [2:0]           chk_q, chk_d;
  logic                 clear_sel_q, clear_sel_d;
  logic                 start_sel_q, start_sel_d;
  logic                 my_turn_q, my_turn_d;
  logic                 send_valid_q, send_valid_d;
  logic [NUM_W-1:0]     send_num_q, send_num_d;
  logic                 win_local_q, win_local_d;
  logic                 win_peer_q, win_peer_d;

  logic [NUM_CELLS-1:0] local_mask, peer_mask;
  logic                 local_ok, peer_ok;
  logic                 reached_win, peer_won;

  assign local_mask  = num_to_mask(pick_num);
  assign peer_mask   = num_to_mask(peer_num);
  assign local_ok    = pick_valid && |(local_mask & ~called_q);
  assign peer_ok     = peer_valid && |(peer_mask & ~called_q);
  assign reached_win = {28'd0, line_count} >= 32'(WIN_LINES);
  assign peer_won    = peer_win;

`ifdef TURN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]  to_q, to_d;
  logic [NUM_W-1:0] auto_num;
  logic             auto_valid;
  logic             timeout_hit;

  lowest_free_finder u_finder (
    .mask_i  (called_q),
    .num_o   (auto_num),
    .valid_o (auto_valid)
  );

  assign timeout_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1)) && auto_valid;

  // Counter only advances while staying in MY_TURN, so any exit restarts it.
  always_comb begin
    to_d = '0;
    if (state_q == MY_TURN && state_d == MY_TURN) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) to_q <= '0;
    else                       to_q <= to_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    called_d     = called_q;
    first_d      = first_q;
    last_local_d = last_local_q;
    chk_d        = chk_q;
    clear_sel_d  = 1'b0;
    start_sel_d  = 1'b0;
    send_valid_d = 1'b0;
    send_num_d   = send_num_q;
    win_local_d  = win_local_q;
    win_peer_d   = win_peer_q;

    unique case (state_q)
      IDLE, OVER: begin
        if (game_start) begin
          state_d     = SETUP;
          first_d     = first_player;
          called_d    = '0;
          win_local_d = 1'b0;
          win_peer_d  = 1'b0;
          clear_sel_d = 1'b1;
          start_sel_d = 1'b1;
        end
      end
      SETUP:     state_d = WAIT_SEL;
      WAIT_SEL:  if (sel_done) state_d = WAIT_PEER;
      WAIT_PEER: if (peer_ready) state_d = first_q ? MY_TURN : PEER_TURN;
      MY_TURN: begin
        if (local_ok) begin
          called_d     = called_q | local_mask;
          send_valid_d = 1'b1;
          send_num_d   = pick_num;
          last_local_d = 1'b1;
          chk_d        = '0;
          state_d      = CHECK;
        end
`ifdef TURN_TIMEOUT_EN
        else if (timeout_hit) begin
          called_d     = called_q | num_to_mask(auto_num);
          send_valid_d = 1'b1;
          send_num_d   = auto_num;
          last_local_d = 1'b1;
          chk_d        = '0;
          state_d      = CHECK;
        end
`endif
      end
      PEER_TURN: begin
        if (peer_ok) begin
          called_d     = called_q | peer_mask;
          last_local_d = 1'b0;
          chk_d        = '0;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (chk_q == 3'(CHECK_LAT - 1)) begin
          win_local_d = reached_win;
          win_peer_d  = peer_won;
          if (reached_win || peer_won) state_d = OVER;
          else if (&called_q)          state_d = OVER;
          else                         state_d = last_local_q ? PEER_TURN : MY_TURN;
        end else begin
          chk_d = chk_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    my_turn_d = (state_d == MY_TURN);
  end

  // Either reset source wins over everything, including a same-cycle game_start.
  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q      <= IDLE;
      called_q     <= '0;
      first_q      <= 1'b0;
      last_local_q <= 1'b0;
      chk_q        <= '0;
      clear_sel_q  <= 1'b0;
      start_sel_q  <= 1'b0;
      my_turn_q    <= 1'b0;
      send_valid_q <= 1'b0;
      send_num_q   <= '0;
      win_local_q  <= 1'b0;
      win_peer_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      called_q     <= called_d;
      first_q      <= first_d;
      last_local_q <= last_local_d;
      chk_q        <= chk_d;
      clear_sel_q  <= clear_sel_d;
      start_sel_q  <= start_sel_d;
      my_turn_q    <= my_turn_d;
      send_valid_q <= send_valid_d;
      send_num_q   <= send_num_d;
      win_local_q  <= win_local_d;
      win_peer_q   <= win_peer_d;
    end
  end

  assign state      = state_q;
  assign called     = called_q;
  assign clear_sel  = clear_sel_q;
  assign start_sel  = start_sel_q;
  assign my_turn    = my_turn_q;
  assign send_valid = send_valid_q;
  assign send_num   = send_num_q;
  assign win_local  = win_local_q;
  assign win_peer   = win_peer_q;

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 The block SHALL have parameter WIN_LINES, default 5, meaning completed lines needed to win.
REQ-002 The block SHALL have parameter CHECK_LAT, default 2, meaning cycles spent in CHECK waiting for the line checker (legal range 1..7).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning MY_TURN cycles before auto-pick (used only with the macro).
REQ-004 The block SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- interboard_rst, in, 1: peer-initiated abort, synchronous, active-high.
- game_start, in, 1: one-cycle start pulse.
- first_player, in, 1: 1 = local moves first; sampled with game_start.
- sel_done, in, 1: local board selection finished.
- peer_ready, in, 1: level; peer board selection finished.
- pick_valid, in, 1: local pick strobe.
- pick_num, in, 5: local number.
- peer_valid, in, 1: peer pick strobe.
- peer_num, in, 5: peer number.
- line_count, in, 4: local completed lines.
- peer_win, in, 1: peer reports win.
- clear_sel, out, 1: pulse to the board-select block.
- start_sel, out, 1: pulse to the board-select block.
- my_turn, out, 1: local turn.
- called, out, 25: bit n-1 set = number n called.
- send_valid, out, 1: pulse.
- send_num, out, 5: accepted local number.
- state, out, 3: FSM state.
- win_local, out, 1: local win flag.
- win_peer, out, 1: peer win flag.

Function
REQ-005 The FSM states SHALL be IDLE=0, SETUP=1, WAIT_SEL=2, WAIT_PEER=3, MY_TURN=4, PEER_TURN=5, CHECK=6, OVER=7.
REQ-006 IDLE or OVER with game_start SHALL go to SETUP, latch first_player, and clear called, win_local and win_peer; game_start in any other state SHALL be ignored.
REQ-007 SETUP SHALL last exactly one cycle, asserting clear_sel and start_sel for exactly that cycle, then go to WAIT_SEL.
REQ-008 WAIT_SEL SHALL go to WAIT_PEER on sel_done; WAIT_PEER SHALL go to MY_TURN if latched first_player=1, else PEER_TURN, in the first cycle peer_ready=1.
REQ-009 A local pick SHALL be accepted only in MY_TURN with pick_valid=1, pick_num in 1..25 and called[pick_num-1]=0; otherwise it SHALL be ignored with no state change.
REQ-010 On acceptance, next cycle: called bit set, send_valid=1 for one cycle with send_num=pick_num, state=CHECK, my_turn=0.
REQ-011 A peer pick SHALL be accepted under the same rules in PEER_TURN using peer_valid/peer_num; it SHALL set the called bit and go to CHECK without send_valid.
REQ-012 pick_valid SHALL be ignored in PEER_TURN, and peer_valid SHALL be ignored in MY_TURN.
REQ-013 CHECK SHALL last exactly CHECK_LAT cycles and evaluate in its last cycle:
- win_local = (line_count >= WIN_LINES); win_peer = peer_win; both MAY be set together.
- If either flag is set, go to OVER.
- Else if all 25 called bits are set, go to OVER with both flags 0 (draw).
- Else go to the turn opposite to the side that just picked.
REQ-014 my_turn SHALL equal (state==MY_TURN); outputs SHALL be registered.

Reset
REQ-015 rst or interboard_rst SHALL, from any state at the next edge, force state=IDLE and called=0, and set every output to 0 (clear_sel, start_sel, my_turn, send_valid, send_num, win_local, win_peer all 0).
REQ-016 Reset SHALL take priority over every concurrent input, including game_start.

Configuration
REQ-017 With TURN_TIMEOUT_EN defined, a counter SHALL run in MY_TURN and clear on leaving it.
REQ-018 With TURN_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 with no accepted pick, the block SHALL accept the lowest uncalled number exactly as in REQ-010.
REQ-019 With TURN_TIMEOUT_EN defined, a valid pick in the same cycle as the timeout SHALL win over the auto-pick.
REQ-020 Without TURN_TIMEOUT_EN, the counter and auto-pick logic SHALL be absent, and MY_TURN SHALL wait indefinitely.

Structure
REQ-021 The shared package bingo_pkg SHALL hold the state encodings, NUM_CELLS=25 and NUM_W=5.
REQ-022 The lowest-uncalled priority encoder SHALL be sub-module lowest_free_finder (25-bit mask in, 5-bit number plus valid out), instantiated only under TURN_TIMEOUT_EN.

Verification
REQ-023 The bench SHALL cover: game_start with first_player=1, sel_done, peer_ready -> start_sel and clear_sel high one cycle in SETUP, then state=MY_TURN.
REQ-024 The bench SHALL cover: in MY_TURN, pick 7 -> called[6]=1, send_valid one cycle with send_num=7; after 2 CHECK cycles with line_count=0 -> PEER_TURN.
REQ-025 The bench SHALL cover: repeat pick 7, then pick 0, then pick 26 in MY_TURN -> all ignored, state stays MY_TURN, no send_valid.
REQ-026 The bench SHALL cover: line_count=5 and peer_win=1 in the final CHECK cycle -> OVER with win_local=1 and win_peer=1; all 25 called with no win -> OVER with both flags 0.
REQ-027 The bench SHALL cover: interboard_rst during PEER_TURN -> IDLE with called=0 next cycle; with TURN_TIMEOUT_EN, TIMEOUT_CYCLES=8 and numbers 1,2 called -> auto send_num=3 after 8 idle cycles.
